// File: rtl/uart_cal_ctrl.sv
// Calculator sequencer: parses "A op B =" from rx bytes, sends the decimal result (or "E" CR LF) to tx.
// Latency: CALC 1 cycle, CONV <= 60 cycles; each tx byte waits on tx_done plus TX_GAP; rx bytes are dropped while busy.
module uart_cal_ctrl #(
   parameter int TX_GAP = 0
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       uout_valid,
   input  logic       tx_done,
   output logic       busy
);

   typedef enum logic [2:0] {S_A, S_B, S_CALC, S_CONV, S_SEND, S_WAIT, S_GAP, S_ERR} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

   localparam logic [15:0] GAP_LOAD = (TX_GAP > 0) ? 16'(TX_GAP - 1) : 16'd0;

   state_t          r_state;
   op_t             r_op;
   logic [9:0]      r_a, r_b;
   logic [1:0]      r_cnt_a, r_cnt_b;
   logic            r_neg;
   logic [19:0]     r_mag;
   logic [2:0]      r_idx;
   logic [3:0]      r_dig;
   logic            r_seen;
   logic [2:0]      r_first;
   logic [5:0][3:0] r_buf;
   logic [3:0]      r_ptr;
   logic [15:0]     r_gap;
   logic [7:0]      r_tx_data;
   logic            r_uout_valid;
   logic            r_busy;

   logic            w_is_dig, w_is_op, w_is_term;
   op_t             w_op;
   logic [3:0]      w_dig;
   logic [20:0]     w_res;
   logic [19:0]     w_mag, w_place;
   logic [2:0]      w_first;
   logic [3:0]      w_nxt;
   logic [7:0]      w_byte_cur, w_byte_nxt;

   // Send pointer: 0 '-', 1..6 digit buffer, 7 CR, 8 LF, 9 'E', 10 sequence finished.
   function automatic logic [7:0] byte_of(input logic [3:0] p, input logic [5:0][3:0] dig);
      case (p)
         4'd0:    byte_of = 8'h2D;
         4'd1:    byte_of = {4'h3, dig[0]};
         4'd2:    byte_of = {4'h3, dig[1]};
         4'd3:    byte_of = {4'h3, dig[2]};
         4'd4:    byte_of = {4'h3, dig[3]};
         4'd5:    byte_of = {4'h3, dig[4]};
         4'd6:    byte_of = {4'h3, dig[5]};
         4'd7:    byte_of = 8'h0D;
         4'd8:    byte_of = 8'h0A;
         4'd9:    byte_of = 8'h45;
         default: byte_of = 8'h00;
      endcase
   endfunction

   assign w_is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign w_dig     = rx_data[3:0];
   assign w_is_term = (rx_data == 8'h3D) || (rx_data == 8'h0D);

   always_comb begin
      w_is_op = 1'b1;
      case (rx_data)
         8'h2B:   w_op = OP_ADD;
         8'h2D:   w_op = OP_SUB;
         8'h2A:   w_op = OP_MUL;
         default: begin
            w_op    = OP_ADD;
            w_is_op = 1'b0;
         end
      endcase
   end

   always_comb begin
      case (r_op)
         OP_SUB:  w_res = {11'd0, r_a} - {11'd0, r_b};
         OP_MUL:  w_res = {11'd0, r_a} * {11'd0, r_b};
         default: w_res = {11'd0, r_a} + {11'd0, r_b};
      endcase
   end

   // Result is never below -999, so the low 20 bits carry the full magnitude.
   assign w_mag = w_res[20] ? (~w_res[19:0] + 20'd1) : w_res[19:0];

   always_comb begin
      case (r_idx)
         3'd0:    w_place = 20'd100000;
         3'd1:    w_place = 20'd10000;
         3'd2:    w_place = 20'd1000;
         3'd3:    w_place = 20'd100;
         3'd4:    w_place = 20'd10;
         default: w_place = 20'd1;
      endcase
   end

   assign w_first = r_seen ? r_first : 3'd5;

   always_comb begin
      w_nxt = r_ptr + 4'd1;
      if (r_ptr == 4'd0)      w_nxt = {1'b0, r_first} + 4'd1;
      else if (r_ptr == 4'd8) w_nxt = 4'd10;
      else if (r_ptr == 4'd9) w_nxt = 4'd7;
   end

   assign w_byte_cur = byte_of(r_ptr, r_buf);
   assign w_byte_nxt = byte_of(w_nxt, r_buf);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= S_A;
         r_op         <= OP_ADD;
         r_a          <= '0;
         r_b          <= '0;
         r_cnt_a      <= '0;
         r_cnt_b      <= '0;
         r_neg        <= 1'b0;
         r_mag        <= '0;
         r_idx        <= '0;
         r_dig        <= '0;
         r_seen       <= 1'b0;
         r_first      <= '0;
         r_buf        <= '0;
         r_ptr        <= '0;
         r_gap        <= '0;
         r_tx_data    <= 8'h00;
         r_uout_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_uout_valid <= 1'b0;
         case (r_state)
            S_A: if (rx_valid) begin
               if (w_is_dig) begin
                  if (r_cnt_a == 2'd3) begin
                     r_state <= S_ERR;
                     r_busy  <= 1'b1;
                  end else begin
                     r_a     <= r_a * 10'd10 + {6'd0, w_dig};
                     r_cnt_a <= r_cnt_a + 2'd1;
                  end
               end else if (w_is_op && r_cnt_a != 2'd0) begin
                  r_op    <= w_op;
                  r_state <= S_B;
               end else if (rx_data == 8'h1B) begin
                  r_a     <= '0;
                  r_cnt_a <= '0;
               end else if (rx_data != 8'h20) begin
                  r_state <= S_ERR;
                  r_busy  <= 1'b1;
               end
            end
            S_B: if (rx_valid) begin
               if (w_is_dig) begin
                  if (r_cnt_b == 2'd3) begin
                     r_state <= S_ERR;
                     r_busy  <= 1'b1;
                  end else begin
                     r_b     <= r_b * 10'd10 + {6'd0, w_dig};
                     r_cnt_b <= r_cnt_b + 2'd1;
                  end
               end else if (w_is_term && r_cnt_b != 2'd0) begin
                  r_state <= S_CALC;
                  r_busy  <= 1'b1;
               end else if (rx_data == 8'h1B) begin
                  r_a     <= '0;
                  r_b     <= '0;
                  r_cnt_a <= '0;
                  r_cnt_b <= '0;
                  r_state <= S_A;
               end else if (rx_data != 8'h20) begin
                  r_state <= S_ERR;
                  r_busy  <= 1'b1;
               end
            end
            S_CALC: begin
               r_neg   <= w_res[20];
               r_mag   <= w_mag;
               r_idx   <= '0;
               r_dig   <= '0;
               r_seen  <= 1'b0;
               r_state <= S_CONV;
            end
            S_CONV: begin
               if (r_mag >= w_place) begin
                  r_mag <= r_mag - w_place;
                  r_dig <= r_dig + 4'd1;
               end else begin
                  r_buf[r_idx] <= r_dig;
                  r_dig        <= '0;
                  if (r_dig != 4'd0 && !r_seen) begin
                     r_seen  <= 1'b1;
                     r_first <= r_idx;
                  end
                  if (r_idx == 3'd5) begin
                     r_first <= w_first;
                     r_ptr   <= r_neg ? 4'd0 : {1'b0, w_first} + 4'd1;
                     r_state <= S_SEND;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end
            S_SEND: begin
               r_tx_data    <= w_byte_cur;
               r_uout_valid <= 1'b1;
               r_state      <= S_WAIT;
            end
            S_WAIT: if (tx_done) begin
               if (TX_GAP == 0) begin
                  if (w_nxt == 4'd10) begin
                     r_state <= S_A;
                     r_busy  <= 1'b0;
                     r_a     <= '0;
                     r_b     <= '0;
                     r_cnt_a <= '0;
                     r_cnt_b <= '0;
                  end else begin
                     r_ptr        <= w_nxt;
                     r_tx_data    <= w_byte_nxt;
                     r_uout_valid <= 1'b1;
                  end
               end else begin
                  r_ptr   <= w_nxt;
                  r_gap   <= GAP_LOAD;
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_gap != 16'd0) begin
                  r_gap <= r_gap - 16'd1;
               end else if (r_ptr == 4'd10) begin
                  r_state <= S_A;
                  r_busy  <= 1'b0;
                  r_a     <= '0;
                  r_b     <= '0;
                  r_cnt_a <= '0;
                  r_cnt_b <= '0;
               end else begin
                  r_tx_data    <= w_byte_cur;
                  r_uout_valid <= 1'b1;
                  r_state      <= S_WAIT;
               end
            end
            S_ERR: begin
               r_ptr        <= 4'd9;
               r_tx_data    <= 8'h45;
               r_uout_valid <= 1'b1;
               r_state      <= S_WAIT;
            end
            default: r_state <= S_A;
         endcase
      end
   end

   assign tx_data    = r_tx_data;
   assign uout_valid = r_uout_valid;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// Bench for uart_cal_ctrl: two instances (TX_GAP 0 and 3) share the rx stream, each with its own tx responder.
module tb_uart_cal_ctrl;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data0, tx_data3;
   logic       uv0, uv3, busy0, busy3;
   logic       td0 = 1'b0, td3 = 1'b0;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int resp_delay = 5;
   int cnt0 = 0, cnt3 = 0;
   int n0 = 0, n3 = 0;
   logic [63:0] p0 = '0, p3 = '0;
   int uc0[$], dc0[$], uc3[$], dc3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_cal_ctrl #(.TX_GAP(0)) dut0 (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data0), .uout_valid(uv0), .tx_done(td0), .busy(busy0)
   );

   uart_cal_ctrl #(.TX_GAP(3)) dut3 (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data3), .uout_valid(uv3), .tx_done(td3), .busy(busy3)
   );

   // Transmitter models: capture each strobed byte, answer tx_done resp_delay cycles later.
   initial forever begin
      @(negedge clk);
      td0 = 1'b0;
      if (!n_rst) cnt0 = 0;
      else begin
         if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) begin td0 = 1'b1; dc0.push_back(cyc); end
         end
         if (uv0) begin p0 = {p0[55:0], tx_data0}; n0++; uc0.push_back(cyc); cnt0 = resp_delay; end
      end
   end

   initial forever begin
      @(negedge clk);
      td3 = 1'b0;
      if (!n_rst) cnt3 = 0;
      else begin
         if (cnt3 > 0) begin
            cnt3--;
            if (cnt3 == 0) begin td3 = 1'b1; dc3.push_back(cyc); end
         end
         if (uv3) begin p3 = {p3[55:0], tx_data3}; n3++; uc3.push_back(cyc); cnt3 = resp_delay; end
      end
   end

   task automatic clear_rec();
      n0 = 0; p0 = '0; n3 = 0; p3 = '0;
      uc0.delete(); dc0.delete(); uc3.delete(); dc3.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy0 && !busy3) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (tx_data0 !== 8'h00) $display("FAIL reset_tx_data got=%h want=00", tx_data0); else passes++;
      checks++; if (uv0 !== 1'b0) $display("FAIL reset_uout_valid got=%b want=0", uv0); else passes++;
      checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy0 got=%b want=0", busy0); else passes++;
      checks++; if (busy3 !== 1'b0) $display("FAIL reset_busy3 got=%b want=0", busy3); else passes++;
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_add();
      bit ok;
      resp_delay = 100;
      clear_rec();
      send_str("12+34=");
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL add_timeout busy0=%b busy3=%b want both 0", busy0, busy3); else passes++;
      checks++; if ({n0, p0} !== {32'd4, 64'h34360D0A}) $display("FAIL add_dut0 got n=%0d bytes=%h want n=4 bytes=34360d0a", n0, p0); else passes++;
      checks++; if ({n3, p3} !== {32'd4, 64'h34360D0A}) $display("FAIL add_dut3 got n=%0d bytes=%h want n=4 bytes=34360d0a", n3, p3); else passes++;
      repeat (3) @(negedge clk);
      checks++; if (busy0 !== 1'b0) $display("FAIL add_busy_after got=%b want=0", busy0); else passes++;
      resp_delay = 5;
   endtask

   task automatic test_neg_gap();
      bit ok;
      clear_rec();
      send_str("5-17");
      send_byte(8'h0D);
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL neg_timeout busy0=%b busy3=%b want both 0", busy0, busy3); else passes++;
      checks++; if ({n0, p0} !== {32'd5, 64'h2D31320D0A}) $display("FAIL neg_dut0 got n=%0d bytes=%h want n=5 bytes=2d31320d0a", n0, p0); else passes++;
      checks++; if ({n3, p3} !== {32'd5, 64'h2D31320D0A}) $display("FAIL neg_dut3 got n=%0d bytes=%h want n=5 bytes=2d31320d0a", n3, p3); else passes++;
      checks++;
      if (uc0.size() != 5 || dc0.size() != 5 || uc3.size() != 5 || dc3.size() != 5)
         $display("FAIL gap_counts got %0d/%0d/%0d/%0d want 5/5/5/5", uc0.size(), dc0.size(), uc3.size(), dc3.size());
      else begin
         passes++;
         for (int i = 1; i < 5; i++) begin
            checks++; if (uc3[i] - dc3[i-1] != 4) $display("FAIL gap3_byte%0d got=%0d want=4", i, uc3[i] - dc3[i-1]); else passes++;
            checks++; if (uc0[i] - dc0[i-1] != 1) $display("FAIL gap0_byte%0d got=%0d want=1", i, uc0[i] - dc0[i-1]); else passes++;
         end
      end
   endtask

   task automatic test_arith();
      bit ok;
      string       s_tab[4];
      logic [63:0] v_tab[4];
      int          n_tab[4];
      s_tab = '{"999*999=", "7-7=", "0+0=", "1 + 2 ="};
      v_tab = '{64'h3939383030310D0A, 64'h300D0A, 64'h300D0A, 64'h330D0A};
      n_tab = '{8, 3, 3, 3};
      for (int t = 0; t < 4; t++) begin
         clear_rec();
         send_str(s_tab[t]);
         wait_idle(ok);
         checks++; if (!ok) $display("FAIL arith_timeout case=%s", s_tab[t]); else passes++;
         checks++; if ({n0, p0} !== {n_tab[t], v_tab[t]}) $display("FAIL arith_dut0 case=%s got n=%0d bytes=%h want n=%0d bytes=%h", s_tab[t], n0, p0, n_tab[t], v_tab[t]); else passes++;
         checks++; if ({n3, p3} !== {n_tab[t], v_tab[t]}) $display("FAIL arith_dut3 case=%s got n=%0d bytes=%h want n=%0d bytes=%h", s_tab[t], n3, p3, n_tab[t], v_tab[t]); else passes++;
      end
   endtask

   task automatic test_errors();
      bit ok;
      string s_tab[3];
      s_tab = '{"1234", "+5=", "12/3="};
      for (int t = 0; t < 3; t++) begin
         clear_rec();
         send_str(s_tab[t]);
         send_str("9=");
         wait_idle(ok);
         checks++; if (!ok) $display("FAIL err_timeout case=%s", s_tab[t]); else passes++;
         checks++; if ({n0, p0} !== {32'd3, 64'h450D0A}) $display("FAIL err_dut0 case=%s got n=%0d bytes=%h want n=3 bytes=450d0a", s_tab[t], n0, p0); else passes++;
         checks++; if ({n3, p3} !== {32'd3, 64'h450D0A}) $display("FAIL err_dut3 case=%s got n=%0d bytes=%h want n=3 bytes=450d0a", s_tab[t], n3, p3); else passes++;
         clear_rec();
         send_str("6*7=");
         wait_idle(ok);
         checks++; if ({n0, p0} !== {32'd4, 64'h34320D0A}) $display("FAIL err_recover_dut0 case=%s got n=%0d bytes=%h want n=4 bytes=34320d0a", s_tab[t], n0, p0); else passes++;
         checks++; if ({n3, p3} !== {32'd4, 64'h34320D0A}) $display("FAIL err_recover_dut3 case=%s got n=%0d bytes=%h want n=4 bytes=34320d0a", s_tab[t], n3, p3); else passes++;
      end
   endtask

   task automatic test_esc();
      bit ok;
      clear_rec();
      send_str("12+");
      send_byte(8'h1B);
      send_str("3*4=");
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL esc_timeout busy0=%b busy3=%b", busy0, busy3); else passes++;
      checks++; if ({n0, p0} !== {32'd4, 64'h31320D0A}) $display("FAIL esc_dut0 got n=%0d bytes=%h want n=4 bytes=31320d0a", n0, p0); else passes++;
      checks++; if ({n3, p3} !== {32'd4, 64'h31320D0A}) $display("FAIL esc_dut3 got n=%0d bytes=%h want n=4 bytes=31320d0a", n3, p3); else passes++;
   endtask

   task automatic test_reset_mid_send();
      bit ok;
      int seen;
      clear_rec();
      send_str("100*100=");
      seen = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (uv0) seen++;
         if (seen == 2) break;
      end
      checks++; if (seen != 2) $display("FAIL rst_second_strobe got=%0d want=2", seen); else passes++;
      n_rst = 1'b0;
      #1;
      checks++; if (uv0 !== 1'b0) $display("FAIL rst_async_uout0 got=%b want=0", uv0); else passes++;
      checks++; if (busy0 !== 1'b0) $display("FAIL rst_async_busy0 got=%b want=0", busy0); else passes++;
      checks++; if (busy3 !== 1'b0) $display("FAIL rst_async_busy3 got=%b want=0", busy3); else passes++;
      checks++; if (tx_data0 !== 8'h00) $display("FAIL rst_async_tx_data got=%h want=00", tx_data0); else passes++;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      clear_rec();
      repeat (30) @(negedge clk);
      checks++; if (n0 != 0 || n3 != 0) $display("FAIL rst_no_reissue got=%0d/%0d want=0/0", n0, n3); else passes++;
      send_str("2+2=");
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL rst_after_timeout busy0=%b busy3=%b", busy0, busy3); else passes++;
      checks++; if ({n0, p0} !== {32'd3, 64'h340D0A}) $display("FAIL rst_after_dut0 got n=%0d bytes=%h want n=3 bytes=340d0a", n0, p0); else passes++;
      checks++; if ({n3, p3} !== {32'd3, 64'h340D0A}) $display("FAIL rst_after_dut3 got n=%0d bytes=%h want n=3 bytes=340d0a", n3, p3); else passes++;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "bench time limit");
   end

   initial begin
      test_reset();
      test_add();
      test_neg_gap();
      test_arith();
      test_errors();
      test_esc();
      test_reset_mid_send();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
